rgb_pixel_stage: RTL

- Streaming pixel-processing stage directly downstream of the BMP image-read block.
- Consumes R/G/B pixels in corrected raster order (row 0 first, left to right), one pixel per handshake.
- Applies per-frame brightness offset, grayscale conversion or binary threshold.
- Emits a valid/ready stream with frame and line markers for the downstream BMP-write stage.

---
 rtl/img_pkg.sv | 22 ++
 rtl/rgb_clamp_gray.sv | 33 +++
 rtl/rgb_pixel_stage.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/img_pkg.sv
// Shared definitions for the BMP pixel pipeline: mode encoding, gray weights, pixel type.
package img_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_BRIGHT = 2'd1,
    MODE_GRAY   = 2'd2,
    MODE_THRESH = 2'd3
  } mode_e;

  localparam int GR_R     = 77;
  localparam int GR_G     = 150;
  localparam int GR_B     = 29;
  localparam int GR_SHIFT = 8;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

endpackage

// File: rtl/rgb_clamp_gray.sv
// Combinational pixel helpers: saturating signed offset per channel and luma-weighted gray.
module rgb_clamp_gray
  import img_pkg::*;
(
  input  rgb24_t            i_pix,
  input  logic signed [8:0] i_off,
  output rgb24_t            o_sat,
  input  rgb24_t            i_gpix,
  output logic [7:0]        o_gray
);

  function automatic logic [7:0] sat_add(input logic [7:0] c, input logic signed [8:0] off);
    logic signed [9:0] s;
    s = $signed({2'b00, c}) + $signed({off[8], off});
    if (s < 10'sd0)        return 8'd0;
    else if (s > 10'sd255) return 8'hFF;
    else                   return s[7:0];
  endfunction

  logic [15:0] w_acc;

  always_comb begin
    o_sat.r = sat_add(i_pix.r, i_off);
    o_sat.g = sat_add(i_pix.g, i_off);
    o_sat.b = sat_add(i_pix.b, i_off);
  end

  // Weights sum to 256, so the shifted result always fits in 8 bits.
  assign w_acc  = 16'(GR_R) * 16'(i_gpix.r) + 16'(GR_G) * 16'(i_gpix.g)
                + 16'(GR_B) * 16'(i_gpix.b);
  assign o_gray = 8'(w_acc >> GR_SHIFT);

endmodule

// File: rtl/rgb_pixel_stage.sv
// Two-stage streaming pixel processor: brightness, then gray/threshold, with frame markers.
module rgb_pixel_stage
  import img_pkg::*;
#(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int COL_W  = 10,
  parameter int ROW_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic signed [8:0] bright_off,
  input  logic [7:0]        thresh,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_r,
  input  logic [7:0]        in_g,
  input  logic [7:0]        in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_r,
  output logic [7:0]        out_g,
  output logic [7:0]        out_b,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              done
);

  localparam int STAGES = 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e            r_state, w_next;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  mode_e             r_mode;
  logic signed [8:0] r_off;
  logic [7:0]        r_thresh;
  logic [STAGES:1]   r_vld_pipe;
  rgb24_t            r_s1_pix, r_s2_pix;
  logic [2:0]        r_s1_flg, r_s2_flg;   // {sof, eol, eof}

  rgb24_t            w_in_pix, w_sat, w_s1, w_s2;
  logic [7:0]        w_gray;
  logic              w_adv, w_acc, w_last_col, w_last_row;
  logic [2:0]        w_flg;

  assign w_in_pix   = '{r: in_r, g: in_g, b: in_b};
  assign w_adv      = !r_vld_pipe[STAGES] || out_ready;
  assign w_acc      = in_valid && in_ready;
  assign w_last_col = (r_col == COL_W'(WIDTH - 1));
  assign w_last_row = (r_row == ROW_W'(HEIGHT - 1));
  assign w_flg      = {(r_col == '0) && (r_row == '0), w_last_col, w_last_col && w_last_row};

  rgb_clamp_gray u_cg (
    .i_pix  (w_in_pix),
    .i_off  (r_off),
    .o_sat  (w_sat),
    .i_gpix (r_s1_pix),
    .o_gray (w_gray)
  );

  assign w_s1 = (r_mode == MODE_PASS) ? w_in_pix : w_sat;

  always_comb begin
    w_s2 = r_s1_pix;
    case (r_mode)
      MODE_GRAY:   w_s2 = '{r: w_gray, g: w_gray, b: w_gray};
      MODE_THRESH: w_s2 = (w_gray >= r_thresh) ? '1 : '0;
      default:     w_s2 = r_s1_pix;
    endcase
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_RUN;
      S_RUN: begin
        busy     = 1'b1;
        in_ready = w_adv;
        if (in_valid && w_adv && w_last_col && w_last_row) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (out_valid && out_ready && out_eof) begin
          w_next = S_IDLE;
          done   = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col    <= '0;
      r_row    <= '0;
      r_mode   <= MODE_PASS;
      r_off    <= '0;
      r_thresh <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_col    <= '0;
      r_row    <= '0;
      r_mode   <= mode_e'(mode);
      r_off    <= bright_off;
      r_thresh <= thresh;
    end else if (w_acc) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Whole pipeline moves in lockstep; a stall freezes both stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_s1_pix   <= '0;
      r_s2_pix   <= '0;
      r_s1_flg   <= '0;
      r_s2_flg   <= '0;
    end else if (w_adv) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_acc};
      r_s1_pix   <= w_s1;
      r_s1_flg   <= w_acc ? w_flg : 3'b000;
      r_s2_pix   <= w_s2;
      r_s2_flg   <= r_vld_pipe[1] ? r_s1_flg : 3'b000;
    end
  end

  assign out_valid = r_vld_pipe[STAGES];
  assign out_r     = r_s2_pix.r;
  assign out_g     = r_s2_pix.g;
  assign out_b     = r_s2_pix.b;
  assign out_sof   = r_s2_flg[2];
  assign out_eol   = r_s2_flg[1];
  assign out_eof   = r_s2_flg[0];

endmodule
